// File: rtl/score_keeper.sv
// Match scorer: per-player BCD point counters with edge-detected point
// requests, optional win-by-two detection and a GAME_OVER freeze until clear.
module score_keeper #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned WIN_BY_TWO  = 1,
    parameter int unsigned WRAP        = 0
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            clear_i,
    input  logic [NUM_PLAYERS-1:0]          score_in_i,
    output logic [NUM_PLAYERS*DIGITS*4-1:0] score_bcd_o,
    output logic                            point_stb_o,
    output logic [NUM_PLAYERS-1:0]          point_who_o,
    output logic                            game_over_o,
    output logic [NUM_PLAYERS-1:0]          winner_o
);

    localparam int unsigned MAX_SCORE = (10 ** DIGITS) - 1;
    localparam int unsigned CNT_W     = $clog2(10 ** DIGITS);
    localparam int unsigned SLICE_W   = DIGITS * 4;
    localparam int unsigned BCD_W     = NUM_PLAYERS * SLICE_W;

    typedef enum logic {
        PLAY      = 1'b0,
        GAME_OVER = 1'b1
    } state_e;

    state_e                   state_q;
    logic [NUM_PLAYERS-1:0]   score_in_q;
    logic [BCD_W-1:0]         bcd_q;
    logic [BCD_W-1:0]         bcd_d;
    logic [CNT_W-1:0]         cnt_q [NUM_PLAYERS];
    logic [CNT_W-1:0]         cnt_d [NUM_PLAYERS];
    logic                     point_stb_q;
    logic [NUM_PLAYERS-1:0]   point_who_q;
    logic [NUM_PLAYERS-1:0]   winner_q;

    logic [NUM_PLAYERS-1:0]   req_c;
    logic [NUM_PLAYERS-1:0]   win_vec_c;
    logic [SLICE_W-1:0]       bcd_step;
    logic [3:0]               dig;
    logic                     carry;
    logic                     win_ok;
    logic                     win_found;

    // Rising-edge detect on the per-player point requests
    assign req_c = score_in_i & ~score_in_q;

    // Post-update scores: BCD ripple increment with matching shadow binary count
    always_comb begin
        bcd_d    = bcd_q;
        bcd_step = '0;
        dig      = '0;
        carry    = 1'b0;
        for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
            cnt_d[p] = cnt_q[p];
            bcd_step = bcd_q[p*SLICE_W +: SLICE_W];
            carry    = 1'b1;
            for (int d = 0; d < int'(DIGITS); d++) begin
                dig = bcd_step[d*4 +: 4];
                if (carry) begin
                    if (dig == 4'd9) begin
                        dig = 4'd0;
                    end else begin
                        dig   = dig + 4'd1;
                        carry = 1'b0;
                    end
                end
                bcd_step[d*4 +: 4] = dig;
            end
            if (req_c[p]) begin
                if (cnt_q[p] == CNT_W'(MAX_SCORE)) begin
                    // All-nines: ripple already produced zero; saturate keeps value
                    if (WRAP != 0) begin
                        bcd_d[p*SLICE_W +: SLICE_W] = bcd_step;
                        cnt_d[p]                    = '0;
                    end
                end else begin
                    bcd_d[p*SLICE_W +: SLICE_W] = bcd_step;
                    cnt_d[p]                    = cnt_q[p] + CNT_W'(1);
                end
            end
        end
    end

    // Win check on post-update counts; lowest index wins a tie
    always_comb begin
        win_vec_c = '0;
        win_found = 1'b0;
        win_ok    = 1'b0;
        if (WIN_SCORE != 0) begin
            for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
                win_ok = (32'(cnt_d[p]) >= WIN_SCORE);
                if (WIN_BY_TWO != 0) begin
                    for (int o = 0; o < int'(NUM_PLAYERS); o++) begin
                        if ((o != p) && (32'(cnt_d[p]) < (32'(cnt_d[o]) + 32'd2))) begin
                            win_ok = 1'b0;
                        end
                    end
                end
                if (win_ok && !win_found) begin
                    win_vec_c[p] = 1'b1;
                    win_found    = 1'b1;
                end
            end
        end
    end

    // Match FSM with registered scores, strobes and winner
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= PLAY;
            score_in_q  <= '0;
            bcd_q       <= '0;
            point_stb_q <= 1'b0;
            point_who_q <= '0;
            winner_q    <= '0;
            for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            score_in_q  <= score_in_i;
            point_stb_q <= 1'b0;
            point_who_q <= '0;
            if (clear_i) begin
                state_q  <= PLAY;
                bcd_q    <= '0;
                winner_q <= '0;
                for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
                    cnt_q[p] <= '0;
                end
            end else begin
                case (state_q)
                    PLAY: begin
                        bcd_q       <= bcd_d;
                        point_stb_q <= |req_c;
                        point_who_q <= req_c;
                        for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
                            cnt_q[p] <= cnt_d[p];
                        end
                        if (|win_vec_c) begin
                            state_q  <= GAME_OVER;
                            winner_q <= win_vec_c;
                        end
                    end
                    GAME_OVER: begin
                        state_q <= GAME_OVER;
                    end
                    default: begin
                        state_q <= PLAY;
                    end
                endcase
            end
        end
    end

    assign score_bcd_o = bcd_q;
    assign point_stb_o = point_stb_q;
    assign point_who_o = point_who_q;
    assign game_over_o = (state_q == GAME_OVER);
    assign winner_o    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: three configurations share stimulus and are compared
// each cycle against an integer-score reference model.
module tb_score_keeper;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [1:0]  score_in;

    logic [15:0] bcd_a    [3];
    logic        stb_a    [3];
    logic [1:0]  who_a    [3];
    logic        go_a     [3];
    logic [1:0]  winner_a [3];

    int tests = 0;
    int fails = 0;
    int stb_cnt = 0;

    // Configuration of each instance: win score and wrap mode
    int unsigned win_cfg  [3] = '{11, 0, 0};
    int unsigned wrap_cfg [3] = '{0, 1, 0};

    // Reference model state
    int unsigned m_sc  [3][2];
    logic        m_go  [3];
    logic [1:0]  m_win [3];
    logic        m_stb [3];
    logic [1:0]  m_who [3];
    logic [1:0]  m_prev;

    score_keeper #(.WIN_SCORE(11), .WRAP(0)) dut0 (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .score_in_i(score_in),
        .score_bcd_o(bcd_a[0]), .point_stb_o(stb_a[0]), .point_who_o(who_a[0]),
        .game_over_o(go_a[0]), .winner_o(winner_a[0]));

    score_keeper #(.WIN_SCORE(0), .WRAP(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .score_in_i(score_in),
        .score_bcd_o(bcd_a[1]), .point_stb_o(stb_a[1]), .point_who_o(who_a[1]),
        .game_over_o(go_a[1]), .winner_o(winner_a[1]));

    score_keeper #(.WIN_SCORE(0), .WRAP(0)) dut2 (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .score_in_i(score_in),
        .score_bcd_o(bcd_a[2]), .point_stb_o(stb_a[2]), .point_who_o(who_a[2]),
        .game_over_o(go_a[2]), .winner_o(winner_a[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int unsigned a, input int unsigned b);
        logic [15:0] r;
        r = 16'((((b / 10) % 10) << 12) | ((b % 10) << 8) | (((a / 10) % 10) << 4) | (a % 10));
        return r;
    endfunction

    task automatic model_reset();
        m_prev = 2'b00;
        for (int k = 0; k < 3; k++) begin
            m_sc[k][0] = 0; m_sc[k][1] = 0;
            m_go[k] = 1'b0; m_win[k] = 2'b00; m_stb[k] = 1'b0; m_who[k] = 2'b00;
        end
    endtask

    // One clock of the match rules applied to integer scores
    task automatic model_step(input logic [1:0] s, input logic c);
        logic [1:0] req;
        bit ok;
        bit found;
        req = s & ~m_prev;
        m_prev = s;
        for (int k = 0; k < 3; k++) begin
            m_stb[k] = 1'b0;
            m_who[k] = 2'b00;
            if (c) begin
                m_sc[k][0] = 0; m_sc[k][1] = 0; m_go[k] = 1'b0; m_win[k] = 2'b00;
            end else if (!m_go[k]) begin
                m_who[k] = req;
                m_stb[k] = (req != 2'b00);
                for (int p = 0; p < 2; p++) begin
                    if (req[p]) begin
                        if (m_sc[k][p] == 99) m_sc[k][p] = (wrap_cfg[k] != 0) ? 0 : 99;
                        else m_sc[k][p] = m_sc[k][p] + 1;
                    end
                end
                found = 0;
                if (win_cfg[k] != 0) begin
                    for (int p = 0; p < 2; p++) begin
                        ok = (m_sc[k][p] >= win_cfg[k]) && (m_sc[k][p] >= m_sc[k][1-p] + 2);
                        if (ok && !found) begin
                            found = 1;
                            m_go[k] = 1'b1;
                            m_win[k] = 2'(1 << p);
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_bcd%0d", tag, k), 32'(bcd_a[k]), 32'(to_bcd(m_sc[k][0], m_sc[k][1])));
            chk($sformatf("%s_stb%0d", tag, k), 32'(stb_a[k]), 32'(m_stb[k]));
            chk($sformatf("%s_who%0d", tag, k), 32'(who_a[k]), 32'(m_who[k]));
            chk($sformatf("%s_go%0d", tag, k), 32'(go_a[k]), 32'(m_go[k]));
            chk($sformatf("%s_win%0d", tag, k), 32'(winner_a[k]), 32'(m_win[k]));
        end
    endtask

    task automatic cyc(input logic [1:0] s, input logic c, input string tag);
        @(negedge clk);
        score_in = s;
        clear = c;
        model_step(s, c);
        @(posedge clk);
        #1;
        check_all(tag);
        if (stb_a[0]) stb_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        score_in = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("reset");
        chk("reset_bcd", 32'(bcd_a[0]), 32'h0);

        // T1: ten pulses on player 0
        stb_cnt = 0;
        repeat (10) begin
            cyc(2'b01, 1'b0, "t1");
            cyc(2'b00, 1'b0, "t1");
        end
        chk("t1_bcd", 32'(bcd_a[0]), 32'h0010);
        chk("t1_stb_cnt", 32'(stb_cnt), 32'd10);

        // T2: player 1 held high for 20 cycles counts once
        stb_cnt = 0;
        cyc(2'b10, 1'b0, "t2");
        chk("t2_who", 32'(who_a[0]), 32'h2);
        repeat (19) cyc(2'b10, 1'b0, "t2");
        cyc(2'b00, 1'b0, "t2");
        chk("t2_bcd", 32'(bcd_a[0]), 32'h0110);
        chk("t2_stb_cnt", 32'(stb_cnt), 32'd1);

        // T3: reach 10-10, then win by two at 12-10
        repeat (9) begin
            cyc(2'b10, 1'b0, "t3");
            cyc(2'b00, 1'b0, "t3");
        end
        cyc(2'b01, 1'b0, "t3");
        chk("t3_go_11_10", 32'(go_a[0]), 32'h0);
        cyc(2'b00, 1'b0, "t3");
        cyc(2'b01, 1'b0, "t3");
        chk("t3_go_12_10", 32'(go_a[0]), 32'h1);
        chk("t3_winner", 32'(winner_a[0]), 32'h1);
        repeat (3) begin
            cyc(2'b00, 1'b0, "t3");
            cyc(2'b10, 1'b0, "t3");
        end
        chk("t3_frozen", 32'(bcd_a[0]), 32'h1012);

        // T4: simultaneous points at 5-5
        cyc(2'b00, 1'b1, "t4");
        chk("t4_clear_go", 32'(go_a[0]), 32'h0);
        repeat (5) begin
            cyc(2'b11, 1'b0, "t4");
            cyc(2'b00, 1'b0, "t4");
        end
        cyc(2'b11, 1'b0, "t4");
        chk("t4_who", 32'(who_a[0]), 32'h3);
        chk("t4_bcd", 32'(bcd_a[0]), 32'h0606);
        cyc(2'b00, 1'b0, "t4");

        // T5: max score wrap versus saturate
        cyc(2'b00, 1'b1, "t5");
        repeat (99) begin
            cyc(2'b01, 1'b0, "t5");
            cyc(2'b00, 1'b0, "t5");
        end
        chk("t5_at99", 32'(bcd_a[1]), 32'h0099);
        cyc(2'b01, 1'b0, "t5");
        chk("t5_wrap", 32'(bcd_a[1]), 32'h0000);
        chk("t5_sat", 32'(bcd_a[2]), 32'h0099);
        chk("t5_sat_stb", 32'(stb_a[2]), 32'h1);
        cyc(2'b00, 1'b0, "t5");

        // T6: clear beats a simultaneous rising request
        cyc(2'b00, 1'b1, "t6");
        cyc(2'b01, 1'b0, "t6");
        cyc(2'b00, 1'b0, "t6");
        cyc(2'b01, 1'b1, "t6");
        chk("t6_clr_bcd", 32'(bcd_a[0]), 32'h0);
        chk("t6_clr_stb", 32'(stb_a[0]), 32'h0);
        cyc(2'b01, 1'b0, "t6");
        chk("t6_held_after_clear", 32'(bcd_a[0]), 32'h0);
        cyc(2'b00, 1'b0, "t6");
        cyc(2'b10, 1'b0, "t6");
        chk("t6_pre_reset_bcd", 32'(bcd_a[0]), 32'h0100);

        // Asynchronous reset between clock edges
        #2;
        reset = 1'b1;
        score_in = 2'b00;
        #1;
        model_reset();
        check_all("areset");
        chk("areset_stb", 32'(stb_a[0]), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized play with occasional clears
        repeat (600) begin
            cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
